// File: rtl/lc3_imem_server.sv
// LC3 instruction memory responder: handshaked fetch with programmable latency
// plus a streaming program-load port that writes words into the array.
module lc3_imem_server #(
  parameter int ADDR_BITS = 10,
  parameter int DEPTH     = 1 << ADDR_BITS,
  parameter int LATENCY   = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FETCH_REQ,
  input  logic [15:0] FETCH_ADDR,
  output logic        FETCH_ACK,
  output logic [15:0] FETCH_DATA,
  input  logic        LOAD_START,
  input  logic [15:0] LOAD_ADDR,
  input  logic        LOAD_VALID,
  input  logic        LOAD_LAST,
  input  logic [15:0] LOAD_DATA,
  output logic        LOAD_READY,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t                 state;
  logic [15:0]            mem [DEPTH];
  logic [ADDR_BITS-1:0]   ptr, ptr_nxt, addr;
  logic [3:0]             cnt;

  // Upper address bits alias onto the array and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{FETCH_ADDR[15:ADDR_BITS], LOAD_ADDR[15:ADDR_BITS]};

  assign ptr_nxt = (ptr == ADDR_BITS'(DEPTH - 1)) ? '0 : ptr + 1'b1;

  // Array is never reset so a loaded program survives RESET.
  always_ff @(posedge CLK)
    if (state == LOAD && LOAD_VALID) mem[ptr] <= LOAD_DATA;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      FETCH_ACK  <= 1'b0;
      FETCH_DATA <= 16'h0000;
      LOAD_READY <= 1'b0;
      BUSY       <= 1'b0;
      ptr        <= '0;
      addr       <= '0;
      cnt        <= '0;
    end else begin
      FETCH_ACK <= 1'b0;
      case (state)
        IDLE: begin
          // Load wins a collision; the dropped fetch must be re-requested.
          if (LOAD_START) begin
            ptr        <= LOAD_ADDR[ADDR_BITS-1:0];
            state      <= LOAD;
            LOAD_READY <= 1'b1;
            BUSY       <= 1'b1;
          end else if (FETCH_REQ) begin
            addr  <= FETCH_ADDR[ADDR_BITS-1:0];
            cnt   <= 4'(LATENCY);
            state <= WAIT;
            BUSY  <= 1'b1;
          end
        end
        LOAD: begin
          if (LOAD_VALID) begin
            ptr <= ptr_nxt;
            if (LOAD_LAST) begin
              state      <= IDLE;
              LOAD_READY <= 1'b0;
              BUSY       <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            FETCH_DATA <= mem[addr];
            FETCH_ACK  <= 1'b1;
            state      <= IDLE;
            BUSY       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          LOAD_READY <= 1'b0;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_imem_server.sv
// Bench for lc3_imem_server: two instances (LATENCY=1 and LATENCY=0) share stimulus
// and are checked every cycle against a cycle-indexed reference model.
module tb_lc3_imem_server;
  localparam int AB  = 10;
  localparam int DEP = 1 << AB;

  logic CLK = 1'b0;
  logic RESET;
  logic FETCH_REQ, LOAD_START, LOAD_VALID, LOAD_LAST;
  logic [15:0] FETCH_ADDR, LOAD_ADDR, LOAD_DATA;
  logic [1:0]       ack, ready, busy;
  logic [1:0][15:0] data;

  always #5 CLK = ~CLK;

  lc3_imem_server #(.ADDR_BITS(AB), .LATENCY(1)) u0 (
    .CLK(CLK), .RESET(RESET), .FETCH_REQ(FETCH_REQ), .FETCH_ADDR(FETCH_ADDR),
    .FETCH_ACK(ack[0]), .FETCH_DATA(data[0]), .LOAD_START(LOAD_START),
    .LOAD_ADDR(LOAD_ADDR), .LOAD_VALID(LOAD_VALID), .LOAD_LAST(LOAD_LAST),
    .LOAD_DATA(LOAD_DATA), .LOAD_READY(ready[0]), .BUSY(busy[0]));

  lc3_imem_server #(.ADDR_BITS(AB), .LATENCY(0)) u1 (
    .CLK(CLK), .RESET(RESET), .FETCH_REQ(FETCH_REQ), .FETCH_ADDR(FETCH_ADDR),
    .FETCH_ACK(ack[1]), .FETCH_DATA(data[1]), .LOAD_START(LOAD_START),
    .LOAD_ADDR(LOAD_ADDR), .LOAD_VALID(LOAD_VALID), .LOAD_LAST(LOAD_LAST),
    .LOAD_DATA(LOAD_DATA), .LOAD_READY(ready[1]), .BUSY(busy[1]));

  // Reference model: memory image, burst pointer, and the edge index at which
  // a pending fetch is due to be acknowledged.
  int          lat [2] = '{1, 0};
  logic [15:0] mmem [2][DEP];
  bit          mknown [2][DEP];
  bit          mload [2];
  int          mptr [2], mdue [2], maddr [2];
  bit          mack [2], mdk [2];
  logic [15:0] mdata [2];
  int          cyc = 0;
  int          n_chk = 0, n_fail = 0;

  typedef struct { logic [15:0] addr; logic [15:0] exp; } vec_t;
  vec_t vecs [8];

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mload[k] = 0; mdue[k] = -1; mack[k] = 0; mdata[k] = 16'h0; mdk[k] = 1;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      mack[k] = 0;
      if (mload[k]) begin
        if (LOAD_VALID) begin
          mmem[k][mptr[k]] = LOAD_DATA;
          mknown[k][mptr[k]] = 1;
          mptr[k] = (mptr[k] + 1) % DEP;
          if (LOAD_LAST) mload[k] = 0;
        end
      end else if (mdue[k] >= 0) begin
        if (cyc == mdue[k]) begin
          mack[k] = 1; mdata[k] = mmem[k][maddr[k]]; mdk[k] = mknown[k][maddr[k]];
          mdue[k] = -1;
        end
      end else if (LOAD_START) begin
        mload[k] = 1; mptr[k] = int'(LOAD_ADDR) % DEP;
      end else if (FETCH_REQ) begin
        maddr[k] = int'(FETCH_ADDR) % DEP; mdue[k] = cyc + lat[k] + 1;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("ack", k, 32'(ack[k]), 32'(mack[k]));
      chk("busy", k, 32'(busy[k]), 32'(mload[k] || mdue[k] >= 0));
      chk("load_ready", k, 32'(ready[k]), 32'(mload[k]));
      if (mdk[k]) chk("fetch_data", k, 32'(data[k]), 32'(mdata[k]));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1 check_all();
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic areset();
    #2 RESET = 1'b1;
    #2 model_reset();
    check_all();
    RESET = 1'b0;
  endtask

  task automatic load(logic [15:0] a, logic [15:0] w [$]);
    LOAD_START = 1; LOAD_ADDR = a; tick(); LOAD_START = 0;
    foreach (w[i]) begin
      LOAD_VALID = 1; LOAD_DATA = w[i]; LOAD_LAST = (i == w.size() - 1); tick();
    end
    LOAD_VALID = 0; LOAD_LAST = 0;
  endtask

  task automatic fetch(logic [15:0] a, logic [15:0] exp);
    int s0 = -1, s1 = -1;
    FETCH_REQ = 1; FETCH_ADDR = a; tick(); FETCH_REQ = 0;
    for (int i = 1; i <= 10 && s0 < 0; i++) begin
      tick();
      if (ack[1] && s1 < 0) begin s1 = i; chk("fetch_val", 1, 32'(data[1]), 32'(exp)); end
      if (ack[0]) begin s0 = i; chk("fetch_val", 0, 32'(data[0]), 32'(exp)); end
    end
    chk("fetch_latency", 0, s0, 2);
    chk("fetch_latency", 1, s1, 1);
    tick();
    chk("fetch_hold", 0, 32'(data[0]), 32'(exp));
  endtask

  initial begin
    int acyc [$];
    logic [15:0] adat [$];
    int na0, na1;
    vecs = '{'{16'h03FF, 16'hAAAA}, '{16'h0000, 16'hBBBB}, '{16'h0400, 16'hBBBB},
             '{16'h0001, 16'h1234}, '{16'h0002, 16'hF025}, '{16'h0100, 16'h1111},
             '{16'h0101, 16'h2222}, '{16'h0501, 16'h2222}};
    RESET = 0; FETCH_REQ = 0; FETCH_ADDR = 0; LOAD_START = 0; LOAD_ADDR = 0;
    LOAD_VALID = 0; LOAD_LAST = 0; LOAD_DATA = 0;
    model_reset();
    #3 areset();
    tick();

    // Program load then LATENCY=0 back-to-back with FETCH_REQ held high.
    load(16'h0000, '{16'h3000, 16'h1234, 16'hF025});
    fetch(16'h0001, 16'h1234);
    FETCH_ADDR = 0; FETCH_REQ = 1;
    for (int i = 0; i < 12 && acyc.size() < 3; i++) begin
      tick();
      if (ack[1]) begin
        acyc.push_back(cyc); adat.push_back(data[1]);
        FETCH_ADDR = FETCH_ADDR + 1;
        if (acyc.size() == 3) FETCH_REQ = 0;
      end
    end
    FETCH_REQ = 0;
    chk("b2b_count", 1, acyc.size(), 3);
    if (acyc.size() == 3) begin
      chk("b2b_gap", 1, acyc[1] - acyc[0], 2);
      chk("b2b_gap", 1, acyc[2] - acyc[1], 2);
      chk("b2b_data", 1, 32'(adat[0]), 32'h3000);
      chk("b2b_data", 1, 32'(adat[1]), 32'h1234);
      chk("b2b_data", 1, 32'(adat[2]), 32'hF025);
    end
    repeat (5) tick();

    // Reset while both instances wait on a fetch: no ACK, memory kept.
    FETCH_REQ = 1; FETCH_ADDR = 16'h0002; tick(); FETCH_REQ = 0;
    areset();
    repeat (3) tick();
    fetch(16'h0002, 16'hF025);

    // Wrap across the top of the array, then a stalled burst with read-after-load.
    load(16'h03FF, '{16'hAAAA, 16'hBBBB});
    LOAD_START = 1; LOAD_ADDR = 16'h0100; tick(); LOAD_START = 0;
    LOAD_VALID = 1; LOAD_DATA = 16'h1111; tick();
    LOAD_VALID = 0; LOAD_DATA = 16'hDEAD; LOAD_LAST = 1;
    repeat (3) begin tick(); chk("stall_ready", 0, 32'(ready[0]), 32'd1); end
    LOAD_VALID = 1; LOAD_DATA = 16'h2222; LOAD_LAST = 1; tick();
    LOAD_VALID = 0; LOAD_LAST = 0;
    fetch(16'h0101, 16'h2222);

    foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].exp);

    // Collision: load wins, the fetch is never acknowledged.
    na0 = 0; na1 = 0;
    LOAD_START = 1; FETCH_REQ = 1; LOAD_ADDR = 16'h0200; FETCH_ADDR = 16'h0001;
    tick(); LOAD_START = 0; FETCH_REQ = 0;
    chk("coll_ready", 0, 32'(ready[0]), 32'd1);
    LOAD_VALID = 1; LOAD_LAST = 1; LOAD_DATA = 16'h5555; tick();
    LOAD_VALID = 0; LOAD_LAST = 0;
    repeat (4) begin tick(); na0 += int'(ack[0]); na1 += int'(ack[1]); end
    chk("coll_acks", 0, na0, 0);
    chk("coll_acks", 1, na1, 0);

    // A request pulse during WAIT is ignored: one ACK per accepted fetch.
    na0 = 0; na1 = 0;
    FETCH_REQ = 1; FETCH_ADDR = 16'h0200; tick();
    tick(); na0 += int'(ack[0]); na1 += int'(ack[1]);
    FETCH_REQ = 0;
    repeat (5) begin tick(); na0 += int'(ack[0]); na1 += int'(ack[1]); end
    chk("wait_acks", 0, na0, 1);
    chk("wait_acks", 1, na1, 1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      LOAD_START = ($urandom_range(0, 9) == 0);
      FETCH_REQ  = $urandom_range(0, 1);
      LOAD_ADDR  = 16'($urandom);
      FETCH_ADDR = 16'($urandom);
      LOAD_VALID = ($urandom_range(0, 3) != 0);
      LOAD_LAST  = ($urandom_range(0, 5) == 0);
      LOAD_DATA  = 16'($urandom);
      if ($urandom_range(0, 149) == 0) areset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
